// File: rtl/gray_to_binary_serial.sv
// gray_to_binary_serial: serial MSB-first Gray-to-binary decoder with valid/ready on both sides
module gray_to_binary_serial #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] G,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] B,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
   localparam int IW = $clog2(WIDTH);
   localparam logic [IW-1:0] TOP = IW'(WIDTH - 1);
   state_t r_state, w_next;
   logic [WIDTH-1:0] r_gray, r_work, w_work;
   logic [IW-1:0] r_idx;
   logic w_bit;
   // the top bit has no higher neighbour, so it passes straight through
   always_comb begin
      w_bit = r_gray[r_idx] ^ ((r_idx == TOP) ? 1'b0 : r_work[r_idx + 1'b1]);
      w_work = r_work;
      w_work[r_idx] = w_bit;
      w_next = (r_state == IDLE) ? (in_valid ? CONV : IDLE)
             : (r_state == CONV) ? ((r_idx == '0) ? DONE : CONV)
             : (r_state == DONE && !out_ready) ? DONE : IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_gray  <= '0;
         r_work  <= '0;
         r_idx   <= '0;
         B       <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && in_valid) begin
            r_gray <= G;
            r_work <= '0;
            r_idx  <= TOP;
         end
         if (r_state == CONV) begin
            r_work <= w_work;
            if (r_idx != '0) r_idx <= r_idx - 1'b1;
            else B <= w_work;
         end
      end
   end
   assign in_ready  = (r_state == IDLE) && !rst;
   assign busy      = (r_state == CONV);
   assign out_valid = (r_state == DONE);
endmodule

// File: tb/tb_gray_to_binary_serial.sv
// tb_gray_to_binary_serial: vector table, directed corner sequences and randomized 8-bit traffic
module tb_gray_to_binary_serial;
   logic clk = 0, rst = 1;
   logic iv4 = 0, or4 = 0, ir4, ov4, bz4;
   logic [3:0] g4 = '0, b4;
   logic iv8 = 0, or8 = 0, ir8, ov8, bz8;
   logic [7:0] g8 = '0, b8;
   int n_pass = 0, n_total = 0;

   always #5 clk = ~clk;

   gray_to_binary_serial #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .G(g4),
      .out_valid(ov4), .out_ready(or4), .B(b4), .busy(bz4));
   gray_to_binary_serial #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .G(g8),
      .out_valid(ov8), .out_ready(or8), .B(b8), .busy(bz8));

   typedef struct {
      logic [3:0] g;
      logic [3:0] b;
   } vec_t;
   vec_t tbl[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // reference: each binary bit is the XOR of all Gray bits at or above it
   function automatic logic [7:0] g2b(input logic [7:0] g);
      logic [7:0] b = '0;
      for (int i = 0; i < 8; i++) b ^= g >> i;
      return b;
   endfunction

   task automatic run4(input logic [3:0] g, output logic [3:0] b, output int lat, output bit stable);
      logic [3:0] prev;
      prev = b4;
      g4 = g;
      iv4 = 1;
      tick();
      iv4 = 0;
      lat = 0;
      stable = 1;
      while (!ov4 && lat < 40) begin
         if (b4 !== prev) stable = 0;
         tick();
         lat++;
      end
      b = b4;
   endtask

   task automatic run8(input logic [7:0] g, output logic [7:0] b, output int lat);
      g8 = g;
      iv8 = 1;
      tick();
      iv8 = 0;
      lat = 0;
      while (!ov8 && lat < 60) begin
         tick();
         lat++;
      end
      b = b8;
   endtask

   initial begin
      logic [3:0] r4;
      logic [7:0] r8, g;
      int lat, d;
      bit st;
      tbl = '{'{4'b0000, 4'd0}, '{4'b0001, 4'd1}, '{4'b0011, 4'd2}, '{4'b0010, 4'd3}, '{4'b0110, 4'd4},
              '{4'b0111, 4'd5}, '{4'b0101, 4'd6}, '{4'b0100, 4'd7}, '{4'b1100, 4'd8}, '{4'b1101, 4'd9}};
      repeat (3) tick();
      chk("in_ready during rst", ir4, 0);
      chk("B after rst", b4, 0);
      chk("out_valid after rst", ov4, 0);
      chk("busy after rst", bz4, 0);
      chk("B8 after rst", b8, 0);
      rst = 0;
      #1;
      chk("in_ready after rst release", ir4, 1);
      or4 = 1;
      for (int i = 0; i < 10; i++) begin
         run4(tbl[i].g, r4, lat, st);
         chk($sformatf("tbl B[%0d]", i), r4, tbl[i].b);
         chk($sformatf("tbl latency[%0d]", i), lat, 4);
         chk($sformatf("tbl B stable[%0d]", i), st, 1);
         tick();
         chk($sformatf("tbl in_ready back[%0d]", i), {ir4, ov4}, 2'b10);
      end
      for (int i = 0; i < 16; i++) begin
         logic [3:0] bin;
         bin = 4'(i);
         run4(bin ^ (bin >> 1), r4, lat, st);
         chk($sformatf("round trip %0d", i), r4, bin);
         chk($sformatf("model %0d", i), r4, g2b({4'b0, bin ^ (bin >> 1)}) & 8'h0f);
         tick();
      end
      or8 = 1;
      run8(8'hFF, r8, lat);
      chk("w8 FF", r8, 8'hAA);
      chk("w8 latency", lat, 8);
      tick();
      run8(8'h80, r8, lat);
      chk("w8 80", r8, 8'hFF);
      tick();
      // backpressure
      or4 = 0;
      run4(4'b0110, r4, lat, st);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("bp hold %0d", k), {ov4, ir4, bz4, b4}, {3'b100, 4'd4});
      end
      or4 = 1;
      tick();
      chk("bp release", {ov4, ir4}, 2'b01);
      // in_valid toggling with another word during conversion
      or4 = 0;
      g4 = 4'b1101;
      iv4 = 1;
      tick();
      g4 = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         iv4 = k[0] ? 1'b0 : 1'b1;
         chk($sformatf("toggle in_ready low %0d", k), ir4, 0);
         tick();
      end
      iv4 = 0;
      chk("toggle out_valid", ov4, 1);
      chk("toggle B", b4, 9);
      or4 = 1;
      tick();
      repeat (3) begin
         chk("toggle no capture", {bz4, ov4, ir4}, 3'b001);
         tick();
      end
      // reset mid-conversion at idx=2
      g4 = 4'b1101;
      iv4 = 1;
      tick();
      iv4 = 0;
      tick();
      rst = 1;
      tick();
      chk("midrst B", b4, 0);
      chk("midrst state", {ov4, bz4, ir4}, 3'b000);
      rst = 0;
      #1;
      chk("midrst in_ready", ir4, 1);
      d = 0;
      repeat (6) begin
         if (ov4) d++;
         tick();
      end
      chk("aborted word never shown", d, 0);
      run4(4'b0010, r4, lat, st);
      chk("after midrst B", r4, 3);
      tick();
      // randomized 8-bit traffic with random backpressure
      for (int i = 0; i < 40; i++) begin
         g = 8'($urandom);
         or8 = 0;
         run8(g, r8, lat);
         chk($sformatf("rand B g=%0h", g), r8, g2b(g));
         d = $urandom_range(0, 3);
         repeat (d) begin
            tick();
            chk("rand hold", {ov8, b8}, {1'b1, g2b(g)});
         end
         or8 = 1;
         tick();
         chk("rand release", {ov8, ir8}, 2'b01);
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
